// File: rtl/regfile_cr_core_pkg.sv
// rtl/regfile_cr_core_pkg.sv - shared word type, default geometry and data-row addressing helper
package regfile_cr_core_pkg;

  typedef logic [31:0] word_t;

  localparam int N_DEF       = 16;
  localparam int REGN_DEF    = 512;
  localparam int B_START_DEF = 256;

  // Flat word index of element i of data row r.
  function automatic int data_word_idx(input int b_start, input int n, input int r, input int i);
    return b_start + r * n + i;
  endfunction

endpackage

// File: rtl/regfile_cr_core.sv
// rtl/regfile_cr_core.sv - register file with a bulk-loaded instruction region and a row-written data region
module regfile_cr_core
  import regfile_cr_core_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int REGN    = REGN_DEF,
  parameter int B_START = B_START_DEF
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  input  logic [N-1:0][31:0]          IN_DATA,
  input  logic [REGN/2-1:0][31:0]     IN_INS,
  input  logic [$clog2(N)-1:0]        SEQ_DATC,
  input  logic [$clog2(REGN/2)-1:0]   SEQ_INS,
  output logic [31:0]                 INS_OUT,
  output logic [N-1:0][31:0]          MAT_IN
);

  localparam int ROWS = (REGN - B_START) / N;

  if (B_START != REGN / 2 || ((REGN - B_START) % N) != 0 || ROWS < N) begin : g_bad_params
    $error("regfile_cr_core: illegal geometry N=%0d REGN=%0d B_START=%0d", N, REGN, B_START);
  end

  word_t [REGN-1:0] mem_q;
  word_t [REGN-1:0] mem_d;

  // The whole instruction image is reloaded on every edge.
  for (genvar j = 0; j < B_START; j++) begin : g_ins
    assign mem_d[j] = IN_INS[j];
  end

  // Only the row selected by SEQ_DATC takes new data; all other rows hold.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar i = 0; i < N; i++) begin : g_col
      localparam int W = data_word_idx(B_START, N, r, i);
      assign mem_d[W] = (int'(SEQ_DATC) == r) ? IN_DATA[i] : mem_q[W];
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  word_t [B_START-1:0]     ins_w;
  word_t [ROWS-1:0][N-1:0] rows_w;

  assign ins_w   = mem_q[B_START-1:0];
  assign rows_w  = mem_q[REGN-1:B_START];
  assign INS_OUT = ins_w[SEQ_INS];
  assign MAT_IN  = rows_w[SEQ_DATC];

endmodule

// File: tb/tb_regfile_cr_core.sv
// tb/tb_regfile_cr_core.sv - directed self-checking bench for regfile_cr_core
module tb_regfile_cr_core;

  localparam int N    = 16;
  localparam int REGN = 512;

  logic                  CLK;
  logic                  RSTN;
  logic [N-1:0][31:0]    IN_DATA;
  logic [REGN/2-1:0][31:0] IN_INS;
  logic [3:0]            SEQ_DATC;
  logic [7:0]            SEQ_INS;
  logic [31:0]           INS_OUT;
  logic [N-1:0][31:0]    MAT_IN;

  logic clk_run;
  int   errors;
  int   checks;

  regfile_cr_core #(.N(N), .REGN(REGN), .B_START(REGN/2)) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .IN_DATA (IN_DATA),
    .IN_INS  (IN_INS),
    .SEQ_DATC(SEQ_DATC),
    .SEQ_INS (SEQ_INS),
    .INS_OUT (INS_OUT),
    .MAT_IN  (MAT_IN)
  );

  always begin
    #5;
    if (clk_run) CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_row(input string tag, input logic [31:0] exp);
    for (int i = 0; i < N; i++) check($sformatf("%s[%0d]", tag, i), MAT_IN[i], exp);
  endtask

  task automatic fill_data(input logic [31:0] v);
    for (int i = 0; i < N; i++) IN_DATA[i] = v;
  endtask

  task automatic fill_ins(input logic [31:0] v);
    for (int j = 0; j < REGN/2; j++) IN_INS[j] = v;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    CLK     = 0;
    clk_run = 0;
    RSTN    = 0;
    for (int i = 0; i < N; i++) IN_DATA[i] = $urandom;
    for (int j = 0; j < REGN/2; j++) IN_INS[j] = $urandom;
    SEQ_DATC = 0;
    SEQ_INS  = 0;
    #2;
    check("rst_ins0", INS_OUT, 32'h0);
    check_row("rst_row0", 32'h0);
    SEQ_INS  = 8'd200;
    SEQ_DATC = 4'd9;
    #1;
    check("rst_ins200", INS_OUT, 32'h0);
    check_row("rst_row9", 32'h0);

    fill_ins(32'd8);
    fill_data(32'd5);
    SEQ_DATC = 0;
    SEQ_INS  = 0;
    RSTN     = 1;
    #1;
    check("no_bypass_ins", INS_OUT, 32'h0);
    check("no_bypass_row", MAT_IN[0], 32'h0);
    clk_run = 1;
    tick;
    check("wr1_ins", INS_OUT, 32'd8);
    check_row("wr1_row0", 32'd5);

    fill_ins(32'd5);
    fill_data(32'd9);
    SEQ_DATC = 1;
    SEQ_INS  = 1;
    #2;
    check("pre_edge_row1", MAT_IN[0], 32'h0);
    tick;
    check("wr2_ins", INS_OUT, 32'd5);
    check_row("wr2_row1", 32'd9);
    SEQ_DATC = 0;
    #1;
    check_row("comb_row0", 32'd5);

    RSTN = 0;
    #1;
    check("midrst_ins", INS_OUT, 32'h0);
    check_row("midrst_row0", 32'h0);
    SEQ_DATC = 3;
    fill_data(32'd7);
    tick;
    check("inrst_row3", MAT_IN[0], 32'h0);
    check("inrst_ins", INS_OUT, 32'h0);
    @(negedge CLK);
    RSTN = 1;
    tick;
    check_row("post_rst_row3", 32'd7);
    check("post_rst_ins", INS_OUT, 32'd5);
    SEQ_DATC = 1;
    #1;
    check_row("post_rst_row1", 32'h0);

    for (int j = 0; j < REGN/2; j++) IN_INS[j] = j * 3 + 1;
    for (int r = 0; r < 16; r++) begin
      @(negedge CLK);
      SEQ_DATC = r[3:0];
      fill_data(r + 1);
      tick;
    end
    clk_run = 0;
    #20;
    for (int r = 0; r < 16; r++) begin
      SEQ_DATC = r[3:0];
      #1;
      check_row($sformatf("pat_row%0d", r), r + 1);
    end
    SEQ_INS = 0;
    #1;
    check("pat_ins0", INS_OUT, 32'd1);
    SEQ_INS = 128;
    #1;
    check("pat_ins128", INS_OUT, 32'd385);
    SEQ_INS = 255;
    #1;
    check("pat_ins255", INS_OUT, 32'd766);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_cr_core.md
REGFILE_CR_CORE -- requirements
Module: regfile_cr

Interface
REQ-001 Parameter N, default 16, meaning: words per data row (matrix row width) and width of IN_DATA/MAT_IN.
REQ-002 Parameter REGN, default 512, meaning: total 32-bit words in the register file.
REQ-003 Parameter B_START, default 256, meaning: first word index of the data region; words 0..B_START-1 form the instruction region.
REQ-004 CLK  input  1  sole clock, all state updates on rising edge.
REQ-005 RSTN  input  1  reset, asynchronous, active-low.
REQ-006 IN_DATA  input  N x 32 (packed [N-1:0][31:0])  one data row to be written.
REQ-007 IN_INS  input  REGN/2 x 32 (packed [REGN/2-1:0][31:0])  full instruction image.
REQ-008 SEQ_DATC  input  clog2(N)  data row index, used for both write and read.
REQ-009 SEQ_INS  input  clog2(REGN/2)  instruction word index for read.
REQ-010 INS_OUT  output  32  selected instruction word.
REQ-011 MAT_IN  output  N x 32 (packed [N-1:0][31:0])  selected data row.

Function
REQ-012 Storage SHALL be REGN 32-bit words; instruction region words 0..B_START-1, data region words B_START..REGN-1.
REQ-013 Data region SHALL be organised as (REGN-B_START)/N rows of N words; row r element i = word B_START + r*N + i.
REQ-014 On every rising CLK edge with RSTN=1, word j of the instruction region SHALL take IN_INS[j] for all j < B_START.
REQ-015 On every rising CLK edge with RSTN=1, data row SEQ_DATC element i SHALL take IN_DATA[i] for all i < N; other rows unchanged.
REQ-016 INS_OUT SHALL be combinational: word SEQ_INS of the instruction region.
REQ-017 MAT_IN SHALL be combinational: MAT_IN[i] = data row SEQ_DATC element i.
REQ-018 Write-to-read latency SHALL be zero cycles after the capturing edge: values written at edge k appear on outputs immediately after edge k (no bypass before the edge).
REQ-019 Changing SEQ_DATC/SEQ_INS without a clock edge SHALL change outputs combinationally with no state change.
REQ-020 Parameter legality (elaboration check): B_START = REGN/2, (REGN-B_START) divisible by N, (REGN-B_START)/N >= N so every SEQ_DATC value addresses a valid row.
REQ-021 SEQ_INS covers exactly 0..REGN/2-1; no out-of-range handling needed.

Reset
REQ-022 RSTN=0 SHALL asynchronously clear all REGN words to 0, independent of CLK.
REQ-023 While RSTN=0 no write SHALL occur; INS_OUT and MAT_IN SHALL read 0 for any index.
REQ-024 Reset asserted mid-operation SHALL discard all stored contents; first write occurs on the first rising edge with RSTN=1.

Structure
REQ-025 Shared package SHALL hold word type (32-bit logic) and default constants N=16, REGN=512, B_START=256.
REQ-026 Implementation SHALL be a single module, no sub-modules; storage as a 2-D register array with generate-loop write logic.

Verification
REQ-027 Assert RSTN=0 with arbitrary inputs, no clock -> INS_OUT=0, MAT_IN all 0 for SEQ_INS=0, SEQ_DATC=0.
REQ-028 RSTN=1, IN_INS all 8, IN_DATA all 5, SEQ_DATC=0, one edge -> INS_OUT=8 (SEQ_INS=0), MAT_IN all 5.
REQ-029 Then IN_INS all 5, IN_DATA all 9, SEQ_DATC=1, SEQ_INS=1, one edge -> INS_OUT=5, MAT_IN all 9; set SEQ_DATC=0 without clock -> MAT_IN all 5 (row 0 retained).
REQ-030 Write distinct pattern row r = r+1 for SEQ_DATC 0..15 -> readback each row returns r+1 in all N elements; row 15 maps to words 496..511.
REQ-031 After REQ-029, drop RSTN mid-cycle -> outputs 0 immediately, before next edge; release and clock once with SEQ_DATC=3, IN_DATA all 7 -> row 3 all 7, row 1 reads 0.
